// File: rtl/fsm_cond_pkg.sv
// Shared definitions for the input-conditioner slice.
//
// Contents:
//   btn_state_e          - button debounce FSM states
//   DEF_DEBOUNCE_CYCLES  - default debounce window in clock cycles
//   DEF_TH1..DEF_TH3     - default upward temperature thresholds (codes 1..3)
//   DEF_HYST             - default downward hysteresis margin in raw LSBs
//   up_code()            - highest code n with raw >= THn, 0 if none
package fsm_cond_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_TH1             = 64;
  localparam int unsigned DEF_TH2             = 128;
  localparam int unsigned DEF_TH3             = 192;
  localparam int unsigned DEF_HYST            = 8;

  // Thresholds are strictly increasing, so the first match from the top wins.
  function automatic logic [1:0] up_code(input logic [7:0] raw,
                                         input logic [7:0] th1,
                                         input logic [7:0] th2,
                                         input logic [7:0] th3);
    logic [1:0] code;
    code = 2'd0;
    if (raw >= th3)      code = 2'd3;
    else if (raw >= th2) code = 2'd2;
    else if (raw >= th1) code = 2'd1;
    return code;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debounce FSM.
//
// Ports:
//   clk_i       - clock, all state on the rising edge
//   rst_ni      - asynchronous active-low reset
//   btn_raw_i   - asynchronous bouncing button level, 1 = pressed
//   bt_o        - one-cycle pulse when a press is accepted
//   btn_level_o - debounced button level
//   state_o     - current FSM state (btn_state_e encoding), debug only
//
// The raw level passes a 2-flop synchronizer. A level change is accepted
// only after DEBOUNCE_CYCLES consecutive stable synchronized cycles; any
// bounce restarts the count from zero. For a clean 0->1 step, bt_o rises
// 2+DEBOUNCE_CYCLES cycles after the first edge that samples the 1.
//
// After reset the FSM is disarmed until the synchronizer has refilled and
// shown a released (0) level, so a button held through reset never yields
// a press pulse until it is released and pressed again.
module btn_debounce
  import fsm_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_raw_i,
  output logic       bt_o,
  output logic       btn_level_o,
  output logic [1:0] state_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic [1:0]    prime_q;   // marks the synchronizer output as holding real samples
  logic          lvl;
  logic          lvl_valid;

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          armed_q, armed_d;
  logic          bt_q, bt_d;

  assign lvl       = sync_q[1];
  assign lvl_valid = prime_q[1];
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b00;
      prime_q <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      bt_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw_i};
      prime_q <= {prime_q[0], 1'b1};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      bt_q    <= bt_d;
    end
  end

  // The window closes on the cycle whose count is DEBOUNCE_CYCLES-1 and the
  // level is still stable: that is the DEBOUNCE_CYCLES-th stable cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    bt_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (lvl_valid && !lvl) armed_d = 1'b1;
        if (armed_q && lvl) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!lvl) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          bt_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!lvl) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
      end
      REL_WAIT: begin
        if (lvl) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bt_o        = bt_q;
  assign btn_level_o = (state_q == HELD) || (state_q == REL_WAIT);
  assign state_o     = state_q;

endmodule

// File: rtl/fsm_input_conditioner.sv
// Input conditioner for a Mealy controller: a debounced push-button press
// pulse and a quantized 2-bit temperature code.
//
// Ports:
//   clk             - clock, all state on the rising edge
//   rst_n           - asynchronous active-low reset
//   btn_raw         - asynchronous bouncing button level, 1 = pressed
//   temp_valid      - one-cycle strobe; temp_raw is only looked at when high
//   temp_raw        - 8-bit unsigned sensor sample
//   bt              - one-cycle press pulse
//   btn_level       - debounced button level
//   temp            - quantized temperature code 0..3
//   temp_chg        - one-cycle pulse on the cycle temp takes a new value
//   dbg_btn_state_o - button FSM state (btn_state_e encoding), debug only
//
// Build option: define FSM_COND_TEMP_HYST_EN to enable downward hysteresis.
// With it, the code only drops below c when temp_raw < THc - HYST; without
// it, every valid sample sets temp directly to its threshold code.
//
// The button and temperature paths share no state.
module fsm_input_conditioner
  import fsm_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TH1             = DEF_TH1,
  parameter int unsigned TH2             = DEF_TH2,
  parameter int unsigned TH3             = DEF_TH3,
  parameter int unsigned HYST            = DEF_HYST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       temp_valid,
  input  logic [7:0] temp_raw,
  output logic       bt,
  output logic       btn_level,
  output logic [1:0] temp,
  output logic       temp_chg,
  output logic [1:0] dbg_btn_state_o
);

  localparam logic [7:0] TH1_C = 8'(TH1);
  localparam logic [7:0] TH2_C = 8'(TH2);
  localparam logic [7:0] TH3_C = 8'(TH3);

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .btn_raw_i  (btn_raw),
    .bt_o       (bt),
    .btn_level_o(btn_level),
    .state_o    (dbg_btn_state_o)
  );

  logic [1:0] up_c;
  logic [1:0] temp_q, temp_d;
  logic       temp_chg_q, temp_chg_d;

  assign up_c = up_code(temp_raw, TH1_C, TH2_C, TH3_C);

`ifdef FSM_COND_TEMP_HYST_EN
  // Lower bound a sample must fall under before leaving the current code.
  localparam logic [7:0] DN1 = 8'(TH1 - HYST);
  localparam logic [7:0] DN2 = 8'(TH2 - HYST);
  localparam logic [7:0] DN3 = 8'(TH3 - HYST);

  logic [7:0] dn_thr;

  always_comb begin
    dn_thr = 8'd0;
    case (temp_q)
      2'd1:    dn_thr = DN1;
      2'd2:    dn_thr = DN2;
      2'd3:    dn_thr = DN3;
      default: dn_thr = 8'd0;
    endcase
  end
`endif

  always_comb begin
    temp_d = temp_q;
    if (temp_valid) begin
`ifdef FSM_COND_TEMP_HYST_EN
      if (up_c > temp_q) begin
        temp_d = up_c;
      end else if ((up_c < temp_q) && (temp_raw < dn_thr)) begin
        temp_d = up_c;
      end
`else
      temp_d = up_c;
`endif
    end
  end

  assign temp_chg_d = (temp_d != temp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_q     <= 2'd0;
      temp_chg_q <= 1'b0;
    end else begin
      temp_q     <= temp_d;
      temp_chg_q <= temp_chg_d;
    end
  end

  assign temp     = temp_q;
  assign temp_chg = temp_chg_q;

endmodule

// File: tb/tb_fsm_input_conditioner.sv
`timescale 1ns/1ps
module tb_fsm_input_conditioner;

  localparam int D    = 4;
  localparam int HYST = 8;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_raw;
  logic       temp_valid;
  logic [7:0] temp_raw;
  logic       bt;
  logic       btn_level;
  logic [1:0] temp;
  logic       temp_chg;
  logic [1:0] dbg_btn_state;

  always #5 clk = ~clk;

  fsm_input_conditioner #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_raw        (btn_raw),
    .temp_valid     (temp_valid),
    .temp_raw       (temp_raw),
    .bt             (bt),
    .btn_level      (btn_level),
    .temp           (temp),
    .temp_chg       (temp_chg),
    .dbg_btn_state_o(dbg_btn_state)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int bt_seen  = 0;
  bit check_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button: the debouncer sees each raw sample two edges late. A press is
  // accepted when D+1 equal samples in a row have been seen (the first one
  // starts the window, D more keep it stable); release likewise. Nothing is
  // accepted until a released level has been seen since reset.
  int th [4] = '{0, 64, 128, 192};
  bit raw_hist[$];
  bit m_armed, m_pressed, m_last, m_bt, m_chg, m_v;
  int m_run, m_temp, m_up, m_nt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_hist.delete();
      m_armed = 0; m_pressed = 0; m_last = 0; m_bt = 0; m_chg = 0;
      m_run = 0; m_temp = 0;
    end else begin
      m_bt  = 0;
      m_chg = 0;
      raw_hist.push_back(btn_raw);
      if (raw_hist.size() == 3) begin
        m_v = raw_hist.pop_front();
        if (!m_armed) begin
          if (!m_v) begin
            m_armed = 1; m_last = 0; m_run = 1;
          end
        end else begin
          if (m_v == m_last) m_run++;
          else begin
            m_last = m_v; m_run = 1;
          end
          if (m_v && !m_pressed && m_run == D + 1) begin
            m_pressed = 1; m_bt = 1;
          end else if (!m_v && m_pressed && m_run == D + 1) begin
            m_pressed = 0;
          end
        end
      end
      if (temp_valid) begin
        m_up = 0;
        for (int n = 1; n <= 3; n++) if (int'(temp_raw) >= th[n]) m_up = n;
        m_nt = m_temp;
`ifdef FSM_COND_TEMP_HYST_EN
        if (m_up > m_temp) m_nt = m_up;
        else if (m_up < m_temp && int'(temp_raw) < th[m_temp] - HYST) m_nt = m_up;
`else
        m_nt = m_up;
`endif
        m_chg  = (m_nt != m_temp);
        m_temp = m_nt;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (bt === 1'b1) bt_seen++;
    if (check_en && rst_n) begin
      check("model_bt", int'(bt), int'(m_bt));
      check("model_btn_level", int'(btn_level), int'(m_pressed));
      check("model_temp", int'(temp), m_temp);
      check("model_temp_chg", int'(temp_chg), int'(m_chg));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic temp_sample(input int val, input int exp_t, input int exp_c);
    @(negedge clk);
    temp_valid = 1'b1;
    temp_raw   = 8'(val);
    @(negedge clk);
    temp_valid = 1'b0;
    check("lit_temp", int'(temp), exp_t);
    check("lit_temp_chg", int'(temp_chg), exp_c);
  endtask

  // Waits (bounded) for the next bt pulse; reports its offset from start.
  task automatic wait_bt(input string name, input int start, input int exp_off);
    int found;
    found = -1;
    for (int i = 0; i < 40 && found < 0; i++) begin
      @(negedge clk);
      if (bt === 1'b1) found = cyc - start;
    end
    check(name, found, exp_off);
  endtask

  // Drives pattern bits (LSB first, one per cycle), then holds 1.
  task automatic bounce_press(input string name, input logic [7:0] pat, input int len);
    int s, b0;
    b0 = bt_seen;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      btn_raw = pat[i];
    end
    @(negedge clk);
    btn_raw = 1'b1;
    s = cyc + 1;
    wait_bt(name, s, 6);
    tick(8);
    check({name, "_count"}, bt_seen - b0, 1);
    @(negedge clk);
    btn_raw = 1'b0;
    tick(12);
  endtask

  // ---------------- temperature stimulus table ----------------
  int tv [13] = '{10, 70, 200, 130, 125, 119, 63, 64, 55, 250, 192, 184, 183};
`ifdef FSM_COND_TEMP_HYST_EN
  int tt [13] = '{0, 1, 3, 2, 2, 1, 1, 1, 0, 3, 3, 3, 2};
  int tc [13] = '{0, 1, 1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1};
`else
  int tt [13] = '{0, 1, 3, 2, 1, 1, 0, 1, 0, 3, 3, 2, 2};
  int tc [13] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 0};
`endif

  // ---------------- main sequence ----------------
  initial begin
    int s, b0, r;
    rst_n      = 1'b0;
    btn_raw    = 1'b0;
    temp_valid = 1'b0;
    temp_raw   = 8'd0;
    tick(3);
    check("reset_bt", int'(bt), 0);
    check("reset_btn_level", int'(btn_level), 0);
    check("reset_temp", int'(temp), 0);
    check("reset_temp_chg", int'(temp_chg), 0);
    rst_n    = 1'b1;
    check_en = 1'b1;
    tick(5);

    // clean press, held 20 cycles, then release
    b0 = bt_seen;
    @(negedge clk);
    btn_raw = 1'b1;
    s = cyc + 1;
    wait_bt("press_latency", s, 6);
    @(negedge clk);
    check("press_pulse_width", int'(bt), 0);
    tick(13);
    check("held_level", int'(btn_level), 1);
    check("press_count", bt_seen - b0, 1);
    @(negedge clk);
    btn_raw = 1'b0;
    r = cyc + 1;
    tick(6);
    check("release_level_before", int'(btn_level), 1);
    tick(1);
    check("release_level_after", int'(btn_level), 0);
    check("release_no_pulse", bt_seen - b0, 1);
    tick(10);

    // bounces: alternate toggles, a short run, and exactly D stable ones
    bounce_press("bounce_alt", 8'h05, 4);
    bounce_press("bounce_run3", 8'h07, 4);
    bounce_press("bounce_runD", 8'h0F, 5);

    // quantizer
    for (int i = 0; i < 13; i++) temp_sample(tv[i], tt[i], tc[i]);
    @(negedge clk);
    temp_raw = 8'd0;
    tick(2);
    check("temp_hold_no_valid", int'(temp), 2);

    // simultaneous events, then reset mid-press with temp=3
    @(negedge clk);
    btn_raw    = 1'b1;
    temp_valid = 1'b1;
    temp_raw   = 8'd200;
    s = cyc + 1;
    @(negedge clk);
    temp_valid = 1'b0;
    check("sim_temp", int'(temp), 3);
    check("sim_temp_chg", int'(temp_chg), 1);
    tick(2);
    check("pre_reset_press_wait", int'(dbg_btn_state), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bt", int'(bt), 0);
    check("async_rst_btn_level", int'(btn_level), 0);
    check("async_rst_temp", int'(temp), 0);
    check("async_rst_temp_chg", int'(temp_chg), 0);
    b0 = bt_seen;
    tick(2);
    rst_n = 1'b1;
    tick(30);
    check("held_through_reset_no_pulse", bt_seen - b0, 0);
    check("held_through_reset_level", int'(btn_level), 0);
    @(negedge clk);
    btn_raw = 1'b0;
    tick(10);
    @(negedge clk);
    btn_raw = 1'b1;
    s = cyc + 1;
    wait_bt("repress_latency", s, 6);
    tick(3);
    btn_raw = 1'b0;
    tick(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_input_conditioner.md
FSM_INPUT_CONDITIONER -- requirements
Module: fsm_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized-stable cycles required to accept a button level change; legal range 2..65535.
REQ-002 SHALL have parameters TH1, TH2, TH3, defaults 64, 128, 192: 8-bit upward thresholds for temperature codes 1, 2, 3; constraint TH1 < TH2 < TH3.
REQ-003 SHALL have parameter HYST, default 8: downward hysteresis margin in raw LSBs; constraint HYST < TH1.
REQ-004 SHALL have input clk, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have input rst_n, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have input btn_raw, 1 bit: asynchronous, bouncing push-button level, 1 = pressed.
REQ-007 SHALL have input temp_valid, 1 bit: one-cycle strobe qualifying temp_raw.
REQ-008 SHALL have input temp_raw, 8 bits: unsigned sensor sample.
REQ-009 SHALL have output bt, 1 bit: one-cycle press pulse, intended for the Mealy controller BT input.
REQ-010 SHALL have output btn_level, 1 bit: debounced button level.
REQ-011 SHALL have output temp, 2 bits: quantized temperature code 0..3, intended for the Mealy controller temp input.
REQ-012 SHALL have output temp_chg, 1 bit: one-cycle pulse on the cycle temp takes a new value.

Function
REQ-013 SHALL pass btn_raw through a 2-flop synchronizer before any other use.
REQ-014 SHALL implement the button FSM with states IDLE, PRESS_WAIT, HELD, REL_WAIT.
REQ-015 SHALL transition IDLE->PRESS_WAIT when the synchronized level is 1, clearing the counter.
REQ-016 SHALL, in PRESS_WAIT, return to IDLE if the level drops before DEBOUNCE_CYCLES; otherwise enter HELD, set btn_level=1 and pulse bt.
REQ-017 SHALL handle HELD->REL_WAIT->IDLE symmetrically on a 0 level; btn_level clears on entering IDLE, with no bt pulse on release.
REQ-018 SHALL, for a clean 0->1 step on btn_raw, assert bt exactly 2+DEBOUNCE_CYCLES cycles after the first clk edge that samples the 1, for exactly one cycle.
REQ-019 SHALL restart the counter from 0 on any bounce, so the debounce window is never cumulative.
REQ-020 SHALL saturate the counter at DEBOUNCE_CYCLES; counter width is clog2(DEBOUNCE_CYCLES+1).
REQ-021 SHALL evaluate temp_raw only in cycles where temp_valid=1; temp is updated on the following edge and is otherwise held.
REQ-022 SHALL define up(n) = highest n with temp_raw >= THn, or 0 if none.
REQ-023 SHALL, with current code c, set temp to up(n) if up(n) > c.
REQ-024 SHALL, if up(n) < c, lower temp to up(n) only when temp_raw < THc - HYST; otherwise temp is held.
REQ-025 SHALL allow multi-step jumps (e.g. 0->3) in a single update.
REQ-026 SHALL assert temp_chg in the same cycle temp changes; a valid sample that leaves temp unchanged SHALL NOT pulse it.
REQ-027 SHALL keep the button and temperature paths independent; simultaneous events on both are processed with no interaction.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously force: FSM=IDLE, counter=0, synchronizer=0, bt=0, btn_level=0, temp=0, temp_chg=0.
REQ-029 SHALL abort any debounce in progress on reset mid-press, with no bt pulse produced from the aborted press.
REQ-030 SHALL, after rst_n deasserts, require btn_raw to be observed by the synchronizer and fully debounced before any bt pulse.

Configuration
REQ-031 SHALL, with macro FSM_COND_TEMP_HYST_EN defined, implement the hysteresis of REQ-024.
REQ-032 SHALL, without FSM_COND_TEMP_HYST_EN, set temp = up(n) on every valid sample; HYST is ignored and no hysteresis logic is generated.

Structure
REQ-033 SHALL place the button state enum and the default threshold and hysteresis constants in shared package fsm_cond_pkg.
REQ-034 SHALL implement the synchronizer plus button FSM as sub-module btn_debounce.
REQ-035 SHALL implement the quantizer inline in fsm_input_conditioner.

Verification (DEBOUNCE_CYCLES=4, default thresholds, FSM_COND_TEMP_HYST_EN defined unless noted)
REQ-036 Clean press: btn_raw 0->1 held for 20 cycles -> bt=1 for exactly one cycle, 6 cycles after the first sampling edge; btn_level stays 1 until release.
REQ-037 Bounce: btn_raw toggles 1,0,1,0 on alternate cycles, then holds 1 -> single bt pulse, 6 cycles after the final rising edge.
REQ-038 Quantizer up: valid samples 10, 70, 200 -> temp 0, 1, 3; temp_chg pulses on the 70 and 200 updates only.
REQ-039 Hysteresis: from temp=2, samples 125 then 119 -> temp stays 2, then becomes 1; with the macro undefined, 125 -> 1 immediately.
REQ-040 Reset mid-operation: rst_n pulsed low during PRESS_WAIT with temp=3 -> all outputs 0 asynchronously and no bt pulse afterward while btn_raw stays 1, until btn_raw is released and pressed again.
